// File: rtl/sort_drain.sv
// Output stage for the 8-input bitonic sorter: captures a sorted set in parallel,
// ping-pongs it through two banks and streams it out one word per beat, o1 first.
module sort_drain #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [WIDTH-1:0] i4,
  input  logic [WIDTH-1:0] i5,
  input  logic [WIDTH-1:0] i6,
  input  logic [WIDTH-1:0] i7,
  input  logic [WIDTH-1:0] i8,
  input  logic             dir,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_index,
  output logic             out_last,
  output logic             out_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             order_err
);

  localparam int unsigned NWORDS = 8;
  localparam int unsigned IDXW   = 3;
  localparam int unsigned NBANKS = 2;

  logic [WIDTH-1:0] w_in [NWORDS];
  logic [WIDTH-1:0] r_mem [NBANKS][NWORDS];
  logic [NBANKS-1:0] r_dir;
  logic [NBANKS-1:0] r_full;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [IDXW-1:0]   r_cnt;
  logic              r_order_err;

  logic w_capture;
  logic w_beat;
  logic w_last_beat;
  logic w_order_bad;

  assign w_in[0] = i1;
  assign w_in[1] = i2;
  assign w_in[2] = i3;
  assign w_in[3] = i4;
  assign w_in[4] = i5;
  assign w_in[5] = i6;
  assign w_in[6] = i7;
  assign w_in[7] = i8;

  // Writability comes from registered state only: a bank freed this cycle opens next cycle.
  assign in_ready    = reset & ~r_full[r_wr_bank];
  assign w_capture   = in_valid & in_ready;
  assign out_valid   = r_full[r_rd_bank];
  assign w_beat      = out_valid & out_ready;
  assign w_last_beat = w_beat & (r_cnt == IDXW'(NWORDS - 1));

  // Neighbour check against the declared direction; equal neighbours are legal.
  always_comb begin
    w_order_bad = 1'b0;
    for (int k = 0; k < NWORDS - 1; k++) begin
      if (dir ? (w_in[k] > w_in[k+1]) : (w_in[k] < w_in[k+1])) begin
        w_order_bad = 1'b1;
      end
    end
  end

  // Bank storage is never reset; the full flags decide what is meaningful.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int k = 0; k < NWORDS; k++) begin
        r_mem[r_wr_bank][k] <= w_in[k];
      end
      r_dir[r_wr_bank] <= dir;
    end
  end

  // Capture and final beat always target different banks, so both may update r_full.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_full      <= '0;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_cnt       <= '0;
      r_order_err <= 1'b0;
    end else begin
      if (w_capture) begin
        r_full[r_wr_bank] <= 1'b1;
        r_wr_bank         <= ~r_wr_bank;
        if (w_order_bad) begin
          r_order_err <= 1'b1;
        end
      end
      if (w_beat) begin
        r_cnt <= r_cnt + IDXW'(1);
        if (w_last_beat) begin
          r_full[r_rd_bank] <= 1'b0;
          r_rd_bank         <= ~r_rd_bank;
        end
      end
    end
  end

  assign out_data  = r_mem[r_rd_bank][r_cnt];
  assign out_index = r_cnt;
  assign out_last  = (r_cnt == IDXW'(NWORDS - 1));
  assign out_dir   = r_dir[r_rd_bank];
  assign order_err = r_order_err;

endmodule

// File: tb/tb_sort_drain.sv
// Scoreboard bench for sort_drain: driver queues expected beats at capture,
// a negedge monitor pops and compares every presented word and the status flags.
module tb_sort_drain;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic [W-1:0] data;
    logic [2:0]   idx;
    logic         dir;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] din [8];
  logic         dir;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic [2:0]   out_index;
  logic         out_last;
  logic         out_dir;
  logic         out_valid;
  logic         out_ready;
  logic         order_err;

  beat_t exp_q[$];
  logic  model_err = 1'b0;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    beats = 0;
  int    rmode = 0;
  int    ph = 0;

  sort_drain #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .i1(din[0]), .i2(din[1]), .i3(din[2]), .i4(din[3]),
    .i5(din[4]), .i6(din[5]), .i7(din[6]), .i8(din[7]),
    .dir(dir), .in_ready(in_ready), .out_data(out_data), .out_index(out_index),
    .out_last(out_last), .out_dir(out_dir), .out_valid(out_valid),
    .out_ready(out_ready), .order_err(order_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // A set is in order iff it equals its own sorted copy in the declared direction.
  function automatic bit violates(input logic [W-1:0] w [8], input logic d);
    logic [W-1:0] q[$];
    for (int k = 0; k < 8; k++) q.push_back(w[k]);
    if (d) q.sort();
    else   q.rsort();
    for (int k = 0; k < 8; k++) if (q[k] !== w[k]) return 1'b1;
    return 1'b0;
  endfunction

  // out_ready pattern: 0 always on, 1 always off, 2 random, 3 repeating 1,0,0.
  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      2:       out_ready = 1'($urandom_range(0, 1));
      default: begin
        out_ready = (ph % 3 == 0);
        ph++;
      end
    endcase
  end

  // Monitor: flags against the model, then the presented word against the queue head.
  always @(negedge clk) begin
    logic  exp_ready;
    beat_t e;
    exp_ready = reset && (((exp_q.size() + 7) / 8) < 2);
    chk("in_ready", 64'(in_ready), 64'(exp_ready));
    chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    chk("order_err", 64'(order_err), 64'(model_err));
    if (out_valid && exp_q.size() != 0) begin
      e = exp_q[0];
      chk("out_data", 64'(out_data), 64'(e.data));
      chk("out_index", 64'(out_index), 64'(e.idx));
      chk("out_dir", 64'(out_dir), 64'(e.dir));
      chk("out_last", 64'(out_last), 64'(e.idx == 3'd7));
      if (out_ready) begin
        void'(exp_q.pop_front());
        beats++;
      end
    end else if (!out_valid) begin
      chk("idle_index", 64'(out_index), 64'd0);
      chk("idle_last", 64'(out_last), 64'd0);
    end
  end

  task automatic do_reset(input int n);
    reset    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    model_err = 1'b0;
    repeat (n - 1) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic send_set(input logic [W-1:0] w [8], input logic d);
    bit done = 1'b0;
    for (int k = 0; k < 8; k++) din[k] = w[k];
    dir      = d;
    in_valid = 1'b1;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) exp_q.push_back('{w[k], 3'(k), d});
        if (violates(w, d)) model_err = 1'b1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!done) timeout("send_set");
  endtask

  task automatic wait_idle();
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (exp_q.size() != 0) timeout("wait_idle");
    @(posedge clk);
    #1;
  endtask

  task automatic gen_set(output logic [W-1:0] w [8], output logic d);
    int unsigned q[$];
    int kind;
    kind = $urandom_range(0, 3);
    d    = 1'($urandom_range(0, 1));
    for (int k = 0; k < 8; k++) q.push_back(kind == 3 ? $urandom : $urandom_range(0, 20));
    if (kind <= 1) begin
      if (d) q.sort();
      else   q.rsort();
    end
    for (int k = 0; k < 8; k++) w[k] = W'(q[k]);
  endtask

  logic [W-1:0] s_asc  [8];
  logic [W-1:0] s_desc [8];
  logic [W-1:0] s_bad  [8];
  logic [W-1:0] s_rnd  [8];
  logic         d_rnd;

  initial begin
    s_asc  = '{0, 1, 2, 3, 4, 5, 6, 7};
    s_desc = '{63, 32, 24, 22, 20, 20, 7, 0};
    s_bad  = '{20, 24, 26, 7, 20, 22, 32, 63};
    reset = 1'b0;
    in_valid = 1'b0;
    dir = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) din[k] = '0;

    do_reset(2);
    rmode = 0;
    send_set(s_asc, 1'b1);
    wait_idle();
    send_set(s_desc, 1'b0);
    wait_idle();
    send_set(s_bad, 1'b1);
    wait_idle();
    send_set(s_asc, 1'b1);
    wait_idle();

    // Three sets against a stalled consumer; the third must wait for a bank.
    rmode = 1;
    send_set(s_desc, 1'b0);
    send_set(s_asc, 1'b1);
    fork
      send_set(s_desc, 1'b0);
      begin
        repeat (6) @(posedge clk);
        #1;
        rmode = 0;
      end
    join
    wait_idle();

    rmode = 3;
    send_set(s_asc, 1'b1);
    send_set(s_desc, 1'b0);
    wait_idle();

    // Reset after the third beat while the other bank is full.
    rmode = 1;
    send_set(s_asc, 1'b1);
    send_set(s_desc, 1'b0);
    begin
      int b0;
      int t;
      b0 = beats;
      t  = 0;
      rmode = 0;
      while (beats < b0 + 3 && t < 100) begin
        @(posedge clk);
        #1;
        t++;
      end
      if (beats < b0 + 3) timeout("mid_drain");
    end
    do_reset(2);
    send_set(s_desc, 1'b0);
    wait_idle();

    for (int n = 0; n < 40; n++) begin
      rmode = ($urandom_range(0, 1) != 0) ? 2 : 0;
      gen_set(s_rnd, d_rnd);
      send_set(s_rnd, d_rnd);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    rmode = 0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sort_drain.md
# sort_drain

Output-side companion to the 8-input bitonic sorter `full_CAE`. It captures one sorted 8-word result in parallel, buffers it in a two-bank ping-pong store, and streams the words out serially over a valid/ready interface, o1 first. Each captured set is also checked against the sort direction, and a sticky error flag is raised on any violation. The block sits between the sorter outputs and any serial consumer, such as a FIFO, bus master or UART framer.

## Interface
- `WIDTH`, default 32: data word width; matches the sorter datapath.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-low; `reset`=0 at a rising edge clears all state.
- `in_valid`  in  1: a sorted set is present on `i1`..`i8`.
- `i1`..`i8`  in  WIDTH each: sorter outputs o1..o8.
- `dir`  in  1: direction the set was sorted in, sampled with the set. 1 means ascending, 0 means descending.
- `in_ready`  out  1: a free bank exists; a capture happens when `in_valid` and `in_ready` are both high.
- `out_data`  out  WIDTH: current stream word.
- `out_index`  out  3: position 0..7 of `out_data` within its set.
- `out_last`  out  1: high when `out_index`=7.
- `out_dir`  out  1: `dir` captured with the set being drained.
- `out_valid`  out  1: `out_data` is valid.
- `out_ready`  in  1: consumer accepts; a beat transfers when `out_valid` and `out_ready` are both high.
- `order_err`  out  1: sticky; some captured set violated its `dir` ordering.

## Operation
- Storage
  - Two banks, each holding 8×WIDTH words plus a dir bit and a `full` flag.
  - Pointers: `wr_bank` (1 bit), `rd_bank` (1 bit), `cnt` (3 bits).
- `in_ready` = `reset` & !`full[wr_bank]`. It depends on registered state only; there is no same-cycle bypass from a draining bank.
- Capture (in_valid & in_ready):
  - `i1`..`i8` are written into bank `wr_bank`, word 0..7, together with `dir`.
  - `full[wr_bank]` is set and `wr_bank` toggles.
- Drain:
  - `out_valid` = `full[rd_bank]`.
  - `out_data` = `bank[rd_bank][cnt]`, `out_index` = `cnt`, `out_dir` = `bank[rd_bank].dir`.
  - On each beat, `cnt` increments.
  - On the beat with `cnt`=7, `cnt` wraps to 0, `full[rd_bank]` clears and `rd_bank` toggles.
- Outputs are stable while out_valid & !out_ready. Backpressure stalls `cnt` indefinitely.
- Order check, evaluated combinationally on the inputs at capture:
  - dir=1: error if any i(k) > i(k+1), unsigned compare.
  - dir=0: error if any i(k) < i(k+1), unsigned compare.
  - Equal neighbours are legal in both directions.
  - On error, `order_err` is set. It is cleared only by reset.
  - The offending set is still stored and streamed unchanged.
- Simultaneous events
  - A capture into one bank and the final beat of the other bank in the same cycle are both performed.
  - If both banks are full, `in_ready`=0 even in the cycle the last beat of `rd_bank` is accepted; the freed bank becomes writable next cycle.
  - `in_valid` without `in_ready` is ignored. The sorter side must hold its data, or drop it (upstream policy).
- Reset (`reset`=0 at an edge), including mid-drain:
  - Both `full` flags, `wr_bank`, `rd_bank` and `cnt` go to 0; `order_err` goes to 0.
  - Stored data is discarded and need not be cleared.
  - The partial stream is abandoned; no `out_last` is issued for it.

## Timing
- Reset values, and values while `reset`=0:
  - `out_valid`=0, `out_index`=0, `out_last`=0, `order_err`=0, `in_ready`=0.
  - `out_data` and `out_dir` are don't-care while `out_valid`=0; the RTL drives the bank 0 mux.
- `in_ready`=1 in the first cycle after `reset` returns high.
- Capture at edge k into an empty block gives `out_valid`=1 with word 0 in cycle k+1.
- Sustained throughput: 8 beats per set, one beat per cycle with `out_ready`=1.
  - Back-to-back sets stream with no gap, since the second bank was filled during the first drain.
- `order_err` rises in the cycle after the capturing edge.
- The block accepts at most 2 sets ahead of the consumer; a third capture waits for a full bank to drain.

## Test plan
1. **Basic drain.** Reset low 2 cycles, then high. Capture 0,1,2,3,4,5,6,7 with dir=1 and hold `out_ready`=1.
   - `out_valid` rises one cycle after capture.
   - `out_data` is 0..7 on consecutive cycles, `out_index` 0..7, `out_last` only on 7.
   - `order_err` stays 0.
2. **Descending with duplicates.** Capture 63,32,24,22,20,20,7,0 with dir=0.
   - Stream is in that order, `out_dir`=0, `order_err`=0.
3. **Order violation.** Capture 20,24,26,7,20,22,32,63 with dir=1.
   - `order_err`=1 from the next cycle and stays 1 through later valid sets.
   - The stream still outputs the eight words unchanged.
4. **Ping-pong and full.** Keep `out_ready`=0 and present three sets.
   - First two captures: `in_ready`=1.
   - Third set: `in_ready`=0 until 8 beats of the first set are accepted, then 1 the following cycle.
   - With `out_ready`=1, the 16 beats are continuous with no gap between sets.
5. **Backpressure.** Toggle `out_ready` 1,0,0,1,… during a drain.
   - `out_data` and `out_index` are held during stalls.
   - No word is skipped or duplicated.
6. **Reset mid-drain.** Pull `reset`=0 after beat 3 of a set, with the other bank full.
   - Next cycle: `out_valid`=0, `order_err`=0; `in_ready` stays 0 while `reset`=0.
   - After `reset`=1, `in_ready`=1 and a new capture streams from word 0.
